// File: rtl/pipe_wb_pkg.sv
// Shared types for the multi-channel writeback stage.
// Entry layout, drain FSM states and the hard-wired zero register index.
package pipe_wb_pkg;

   localparam int WB_XLEN  = 32;
   localparam int WB_IDX_W = 5;
   localparam int ZERO_IDX = 0;

   // Entry layout for the default 32-bit / 5-bit-index configuration.
   typedef struct packed {
      logic [WB_IDX_W-1:0] idx;
      logic [WB_XLEN-1:0]  data;
   } wb_entry_t;

   typedef enum logic {
      WB_IDLE  = 1'b0,
      WB_WRITE = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_rr_arb.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module wb_rr_arb #(
   parameter int NUM_CH = 2,
   parameter int PTR_W  = 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [PTR_W-1:0]  gidx,
   output logic              any
);

   int c;

   always_comb begin
      gidx = '0;
      any  = 1'b0;
      c    = 0;
      // Walk from farthest to nearest so the nearest requester wins last.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         c = (int'(ptr) + k) % NUM_CH;
         if (req[c]) begin
            any  = 1'b1;
            gidx = PTR_W'(c);
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (any) begin
         gnt = NUM_CH'(1) << gidx;
      end
   end

endmodule

// File: rtl/pipe_wb_mc.sv
// Writeback stage: round-robin intake, result FIFO, regfile drain,
// forwarding lookup over pending writes and a retire counter.
module pipe_wb_mc
   import pipe_wb_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int IDX_W  = 5,
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic [NUM_CH-1:0]       in_wb_e,
   input  logic [NUM_CH*XLEN-1:0]  in_data,
   input  logic [NUM_CH*IDX_W-1:0] in_idx,
   output logic                    reg_we,
   output logic [IDX_W-1:0]        reg_idx,
   output logic [XLEN-1:0]         reg_data,
   input  logic                    reg_wack,
   input  logic [IDX_W-1:0]        q_idx,
   output logic                    q_hit,
   output logic [XLEN-1:0]         q_data,
   output logic                    busy,
   output logic [CNT_W-1:0]        retired
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW    = $clog2(DEPTH);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [XLEN-1:0]  data;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [AW-1:0]     head;
   logic [AW-1:0]     tail;
   logic [AW:0]       count;
   wb_state_t         state;
   wb_state_t         state_nx;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_nx;

   logic [NUM_CH-1:0] gnt;
   logic [PTR_W-1:0]  gidx;
   logic              any;
   logic              full;
   logic              nonempty;
   logic              accept;
   logic              keep;
   logic              push;
   logic              drop;
   logic              ack;
   logic              pop;
   logic [XLEN-1:0]   sel_data;
   logic [IDX_W-1:0]  sel_idx;

   wb_rr_arb #(
      .NUM_CH(NUM_CH),
      .PTR_W (PTR_W)
   ) u_arb (
      .req (in_valid),
      .ptr (rr_ptr),
      .gnt (gnt),
      .gidx(gidx),
      .any (any)
   );

   assign full     = (count == (AW+1)'(DEPTH));
   assign nonempty = (count != '0);
   assign in_ready = full ? '0 : gnt;
   assign accept   = any & ~full;

   assign sel_data = in_data[int'(gidx)*XLEN +: XLEN];
   assign sel_idx  = in_idx[int'(gidx)*IDX_W +: IDX_W];
   assign keep     = in_wb_e[gidx] & (sel_idx != IDX_W'(ZERO_IDX));
   assign push     = accept & keep;
   assign drop     = accept & ~keep;

   // Pop decision uses registered count: a same-edge push is not visible.
   assign ack = (state == WB_WRITE) & reg_wack;
   assign pop = nonempty & ((state == WB_IDLE) | ack);

   assign rr_nx = (gidx == PTR_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;

   always_comb begin
      state_nx = state;
      case (state)
         WB_IDLE:  if (nonempty) state_nx = WB_WRITE;
         WB_WRITE: if (ack && !nonempty) state_nx = WB_IDLE;
         default:  state_nx = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= WB_IDLE;
         rr_ptr   <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         reg_we   <= 1'b0;
         reg_idx  <= '0;
         reg_data <= '0;
         retired  <= '0;
      end else begin
         state  <= state_nx;
         reg_we <= (state_nx == WB_WRITE);
         if (accept) rr_ptr <= rr_nx;
         if (push) tail <= tail + 1'b1;
         if (pop) begin
            head     <= head + 1'b1;
            reg_idx  <= mem[head].idx;
            reg_data <= mem[head].data;
         end
         count   <= count + (AW+1)'(push) - (AW+1)'(pop);
         retired <= retired + CNT_W'(ack) + CNT_W'(drop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= '{idx: sel_idx, data: sel_data};
      end
   end

   // Scan oldest to youngest so the youngest match overwrites.
   always_comb begin
      q_hit  = 1'b0;
      q_data = '0;
      if (q_idx != IDX_W'(ZERO_IDX)) begin
         if (reg_we && reg_idx == q_idx) begin
            q_hit  = 1'b1;
            q_data = reg_data;
         end
         for (int k = 0; k < DEPTH; k++) begin
            if ((AW+1)'(k) < count &&
                mem[head + AW'(k)].idx == q_idx) begin
               q_hit  = 1'b1;
               q_data = mem[head + AW'(k)].data;
            end
         end
      end
   end

   assign busy = nonempty | reg_we;

endmodule

// File: tb/tb_pipe_wb_mc.sv
// Directed bench for pipe_wb_mc: single write, round-robin, full FIFO,
// drop rules, forwarding lookup and reset during a write.
module tb_pipe_wb_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic [1:0]  in_wb_e;
   logic [63:0] in_data;
   logic [9:0]  in_idx;
   logic        reg_we;
   logic [4:0]  reg_idx;
   logic [31:0] reg_data;
   logic        reg_wack;
   logic [4:0]  q_idx;
   logic        q_hit;
   logic [31:0] q_data;
   logic        busy;
   logic [31:0] retired;

   int checks   = 0;
   int failures = 0;

   pipe_wb_mc #(
      .XLEN  (32),
      .IDX_W (5),
      .NUM_CH(2),
      .DEPTH (4),
      .CNT_W (32)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_wb_e (in_wb_e),
      .in_data (in_data),
      .in_idx  (in_idx),
      .reg_we  (reg_we),
      .reg_idx (reg_idx),
      .reg_data(reg_data),
      .reg_wack(reg_wack),
      .q_idx   (q_idx),
      .q_hit   (q_hit),
      .q_data  (q_data),
      .busy    (busy),
      .retired (retired)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic v, input logic e,
                         input logic [4:0] idx, input logic [31:0] d);
      in_valid[ch]        = v;
      in_wb_e[ch]         = e;
      in_idx[ch*5 +: 5]   = idx;
      in_data[ch*32 +: 32] = d;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = '0;
      in_wb_e  = '0;
      in_data  = '0;
      in_idx   = '0;
      reg_wack = 1'b0;
      q_idx    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (reg_we !== 1'b0 || reg_idx !== 5'd0 || reg_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_reg got we=%0b idx=%0d data=%h exp 0/0/0",
                  reg_we, reg_idx, reg_data);
      end
      checks++;
      if (retired !== 32'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_cnt got retired=%0d busy=%0b exp 0/0",
                  retired, busy);
      end
      checks++;
      if (in_ready !== 2'b00) begin
         failures++;
         $display("FAIL reset_rdy_idle got=%b exp=00", in_ready);
      end
      in_valid = 2'b11;
      #1;
      checks++;
      if (in_ready !== 2'b01) begin
         failures++;
         $display("FAIL reset_rdy_both got=%b exp=01", in_ready);
      end
      in_valid = 2'b00;
   endtask

   task automatic test_single();
      do_reset();
      set_ch(0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      checks++;
      if (in_ready !== 2'b01) begin
         failures++;
         $display("FAIL single_rdy got=%b exp=01", in_ready);
      end
      tick();
      in_valid = '0;
      checks++;
      if (reg_we !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_e1 got we=%0b busy=%0b exp 0/1",
                  reg_we, busy);
      end
      tick();
      checks++;
      if (reg_we !== 1'b1 || reg_idx !== 5'd5 ||
          reg_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_e2 got we=%0b idx=%0d data=%h exp 1/5/deadbeef",
                  reg_we, reg_idx, reg_data);
      end
      tick();
      checks++;
      if (reg_we !== 1'b1 || reg_idx !== 5'd5 ||
          reg_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_hold got we=%0b idx=%0d data=%h exp 1/5/deadbeef",
                  reg_we, reg_idx, reg_data);
      end
      reg_wack = 1'b1;
      tick();
      reg_wack = 1'b0;
      checks++;
      if (reg_we !== 1'b0 || retired !== 32'd1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_done got we=%0b retired=%0d busy=%0b exp 0/1/0",
                  reg_we, retired, busy);
      end
   endtask

   task automatic test_rr();
      logic [1:0]  exp_rdy;
      logic [4:0]  exp_idx;
      logic [31:0] exp_data;
      do_reset();
      reg_wack = 1'b1;
      for (int n = 0; n < 6; n++) begin
         set_ch(0, 1'b1, 1'b1, 5'd1, 32'hA0 + n);
         set_ch(1, 1'b1, 1'b1, 5'd2, 32'hB0 + n);
         #1;
         exp_rdy = (n % 2 == 1) ? 2'b10 : 2'b01;
         checks++;
         if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL rr_grant n=%0d got=%b exp=%b", n, in_ready, exp_rdy);
         end
         tick();
         if (n >= 1) begin
            exp_idx  = ((n - 1) % 2 == 1) ? 5'd2 : 5'd1;
            exp_data = (((n - 1) % 2 == 1) ? 32'hB0 : 32'hA0) + (n - 1);
            checks++;
            if (reg_we !== 1'b1 || reg_idx !== exp_idx ||
                reg_data !== exp_data) begin
               failures++;
               $display("FAIL rr_write n=%0d got we=%0b idx=%0d data=%h exp 1/%0d/%h",
                        n, reg_we, reg_idx, reg_data, exp_idx, exp_data);
            end
         end
      end
      in_valid = '0;
      repeat (2) tick();
      reg_wack = 1'b0;
      checks++;
      if (reg_we !== 1'b0 || retired !== 32'd6 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rr_done got we=%0b retired=%0d busy=%0b exp 0/6/0",
                  reg_we, retired, busy);
      end
   endtask

   task automatic test_full();
      do_reset();
      // One entry moves into the write slot, so five accepts fill 4 queued.
      for (int i = 0; i < 5; i++) begin
         set_ch(0, 1'b1, 1'b1, 5'(10 + i), 32'h1000 + i);
         #1;
         checks++;
         if (in_ready !== 2'b01) begin
            failures++;
            $display("FAIL full_fill i=%0d got=%b exp=01", i, in_ready);
         end
         tick();
      end
      set_ch(0, 1'b1, 1'b1, 5'd15, 32'h1005);
      #1;
      checks++;
      if (in_ready !== 2'b00 || reg_idx !== 5'd10) begin
         failures++;
         $display("FAIL full_block got rdy=%b idx=%0d exp 00/10",
                  in_ready, reg_idx);
      end
      reg_wack = 1'b1;
      tick();
      reg_wack = 1'b0;
      #1;
      checks++;
      if (in_ready !== 2'b01 || retired !== 32'd1) begin
         failures++;
         $display("FAIL full_reopen got rdy=%b retired=%0d exp 01/1",
                  in_ready, retired);
      end
      tick();
      in_valid = '0;
      reg_wack = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (reg_we !== 1'b1 || reg_idx !== 5'(11 + k) ||
             reg_data !== 32'h1001 + k) begin
            failures++;
            $display("FAIL full_drain k=%0d got we=%0b idx=%0d data=%h exp 1/%0d/%h",
                     k, reg_we, reg_idx, reg_data, 11 + k, 32'h1001 + k);
         end
         tick();
      end
      reg_wack = 1'b0;
      checks++;
      if (reg_we !== 1'b0 || retired !== 32'd6 || busy !== 1'b0) begin
         failures++;
         $display("FAIL full_done got we=%0b retired=%0d busy=%0b exp 0/6/0",
                  reg_we, retired, busy);
      end
   endtask

   task automatic test_drop();
      do_reset();
      set_ch(0, 1'b1, 1'b1, 5'd0, 32'h55);
      tick();
      in_valid = '0;
      checks++;
      if (retired !== 32'd1 || busy !== 1'b0 || reg_we !== 1'b0) begin
         failures++;
         $display("FAIL drop_idx0 got retired=%0d busy=%0b we=%0b exp 1/0/0",
                  retired, busy, reg_we);
      end
      set_ch(1, 1'b1, 1'b0, 5'd7, 32'h77);
      #1;
      checks++;
      if (in_ready !== 2'b10) begin
         failures++;
         $display("FAIL drop_rdy got=%b exp=10", in_ready);
      end
      tick();
      in_valid = '0;
      checks++;
      if (retired !== 32'd2 || busy !== 1'b0 || reg_we !== 1'b0) begin
         failures++;
         $display("FAIL drop_wbe0 got retired=%0d busy=%0b we=%0b exp 2/0/0",
                  retired, busy, reg_we);
      end
      set_ch(0, 1'b1, 1'b1, 5'd4, 32'h44);
      tick();
      in_valid = '0;
      tick();
      checks++;
      if (reg_we !== 1'b1 || reg_idx !== 5'd4) begin
         failures++;
         $display("FAIL drop_write got we=%0b idx=%0d exp 1/4",
                  reg_we, reg_idx);
      end
      set_ch(1, 1'b1, 1'b0, 5'd9, 32'h99);
      reg_wack = 1'b1;
      tick();
      reg_wack = 1'b0;
      in_valid = '0;
      checks++;
      if (retired !== 32'd4 || reg_we !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL drop_plus_ack got retired=%0d we=%0b busy=%0b exp 4/0/0",
                  retired, reg_we, busy);
      end
      tick();
      checks++;
      if (reg_we !== 1'b0) begin
         failures++;
         $display("FAIL drop_nowrite got we=%0b exp=0", reg_we);
      end
   endtask

   task automatic test_fwd();
      do_reset();
      set_ch(0, 1'b1, 1'b1, 5'd3, 32'h11);
      q_idx = 5'd3;
      #1;
      checks++;
      if (q_hit !== 1'b0) begin
         failures++;
         $display("FAIL fwd_accepting got hit=%0b exp=0", q_hit);
      end
      tick();
      checks++;
      if (q_hit !== 1'b1 || q_data !== 32'h11) begin
         failures++;
         $display("FAIL fwd_first got hit=%0b data=%h exp 1/11", q_hit, q_data);
      end
      set_ch(0, 1'b1, 1'b1, 5'd3, 32'h22);
      tick();
      set_ch(0, 1'b1, 1'b1, 5'd6, 32'h66);
      tick();
      in_valid = '0;
      #1;
      checks++;
      if (q_hit !== 1'b1 || q_data !== 32'h22) begin
         failures++;
         $display("FAIL fwd_young got hit=%0b data=%h exp 1/22", q_hit, q_data);
      end
      q_idx = 5'd6;
      #1;
      checks++;
      if (q_hit !== 1'b1 || q_data !== 32'h66) begin
         failures++;
         $display("FAIL fwd_other got hit=%0b data=%h exp 1/66", q_hit, q_data);
      end
      q_idx = 5'd0;
      #1;
      checks++;
      if (q_hit !== 1'b0 || q_data !== 32'h0) begin
         failures++;
         $display("FAIL fwd_zero got hit=%0b data=%h exp 0/0", q_hit, q_data);
      end
      q_idx = 5'd9;
      #1;
      checks++;
      if (q_hit !== 1'b0 || q_data !== 32'h0) begin
         failures++;
         $display("FAIL fwd_miss got hit=%0b data=%h exp 0/0", q_hit, q_data);
      end
      reg_wack = 1'b1;
      repeat (3) tick();
      reg_wack = 1'b0;
      q_idx = 5'd3;
      #1;
      checks++;
      if (q_hit !== 1'b0 || retired !== 32'd3 || busy !== 1'b0) begin
         failures++;
         $display("FAIL fwd_drained got hit=%0b retired=%0d busy=%0b exp 0/3/0",
                  q_hit, retired, busy);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_ch(1, 1'b1, 1'b0, 5'd1, 32'h1);
      tick();
      in_valid = '0;
      for (int i = 0; i < 3; i++) begin
         set_ch(0, 1'b1, 1'b1, 5'(20 + i), 32'h20 + i);
         tick();
      end
      in_valid = '0;
      checks++;
      if (reg_we !== 1'b1 || reg_idx !== 5'd20 || retired !== 32'd1) begin
         failures++;
         $display("FAIL mid_pre got we=%0b idx=%0d retired=%0d exp 1/20/1",
                  reg_we, reg_idx, retired);
      end
      #2;
      rst = 1'b1;
      q_idx = 5'd21;
      #1;
      checks++;
      if (reg_we !== 1'b0 || reg_idx !== 5'd0 || reg_data !== 32'd0 ||
          retired !== 32'd0 || busy !== 1'b0 || q_hit !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst got we=%0b idx=%0d data=%h ret=%0d busy=%0b hit=%0b exp all 0",
                  reg_we, reg_idx, reg_data, retired, busy, q_hit);
      end
      @(negedge clk);
      rst = 1'b0;
      reg_wack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (reg_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_after k=%0d got we=%0b busy=%0b exp 0/0",
                     k, reg_we, busy);
         end
      end
      reg_wack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_rr();
      test_full();
      test_drop();
      test_fwd();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
